// File: rtl/hs_arb_pkg.sv
// Shared definitions for the source-domain handshake arbiter:
// FSM state encoding, default geometry and the index-width helper.
package hs_arb_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int DW_DEFAULT   = 26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Bits needed to index n entries (minimum 1 so a degenerate case still has a bit).
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/hs_src_arbiter_rr_pick.sv
// Combinational round-robin picker: searches req_valid starting at ptr and
// wrapping modulo NREQ; the first set bit found wins. NREQ is a power of two,
// so the index addition wraps on its own.
module rr_pick
  import hs_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  localparam int IDW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  grant,
  output logic            any
);

  logic [IDW-1:0] cand;

  // Walk from the farthest offset down to ptr so the closest valid overwrites last.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + IDW'(i);
      if (req_valid[cand]) begin
        grant = cand;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_src_arbiter.sv
// Round-robin scheduler sharing one handshake-synchronizer source port among
// NREQ clk-domain requesters. One word per transfer is registered onto hs_din
// as {id, payload} with a single-cycle hs_sready pulse, then the block waits
// for the synchronizer to report idle again.
//
// Optional build macro: HS_ARB_TIMEOUT_EN enables a WAIT-state watchdog that
// raises the sticky err flag after TIMEOUT cycles in WAIT.
//
// Handshake semantics: req_ready is a one-cycle accept pulse; a requester
// whose req_valid is high in the cycle req_ready[i] is high has had its word
// taken and may then drop or advance its data. Requesters hold req_valid
// until accepted; a valid that drops early is simply no longer considered.
// hs_sidle is only sampled in IDLE and WAIT, never in ISSUE, because the
// synchronizer derives it combinationally from hs_sready.
module hs_src_arbiter
  import hs_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = 1023,
  localparam int IDW    = idx_width(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                hs_sready,
  output logic [IDW+DW-1:0]   hs_din,
  input  logic                hs_sidle,
  output logic                busy,
  output logic                err,
  output logic [1:0]          dbg_state
);

  // Elaboration-time legality checks on the configuration.
  if (NREQ < 2 || NREQ > 8 || (NREQ & (NREQ - 1)) != 0) begin : g_bad_nreq
    $error("hs_src_arbiter: NREQ must be a power of two in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("hs_src_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_e      state, state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  logic            grant_load;
  logic            sready_nxt;
  logic [NREQ-1:0] req_ready_nxt;
  logic            busy_nxt;

  assign dbg_state = state;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_valid (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick_idx),
    .any       (pick_any)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: grant from IDLE, one ISSUE cycle, then wait for idle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (hs_sidle && pick_any) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (hs_sidle) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs and the grant strobe.
  always_comb begin
    grant_load    = (state == ST_IDLE) && hs_sidle && pick_any;
    sready_nxt    = grant_load;
    req_ready_nxt = grant_load ? (NREQ'(1) << pick_idx) : '0;
    busy_nxt      = (state_nxt != ST_IDLE);
  end

  // Registered handshake outputs; pulses last exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sready <= 1'b0;
      req_ready <= '0;
      busy      <= 1'b0;
    end else begin
      hs_sready <= sready_nxt;
      req_ready <= req_ready_nxt;
      busy      <= busy_nxt;
    end
  end

  // Capture the winning word and advance the rotation pointer past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_din <= '0;
      rr_ptr <= '0;
    end else if (grant_load) begin
      hs_din <= {pick_idx, req_data[pick_idx*DW +: DW]};
      rr_ptr <= pick_idx + IDW'(1);
    end
  end

`ifdef HS_ARB_TIMEOUT_EN
  localparam int WD_W = idx_width(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;

  // Watchdog: cleared on the way into WAIT, counts WAIT cycles, saturates at
  // TIMEOUT; err latches once TIMEOUT WAIT cycles have elapsed and stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        wd_cnt <= '0;
      end else if (state == ST_WAIT) begin
        if (wd_cnt != WD_W'(TIMEOUT)) wd_cnt <= wd_cnt + WD_W'(1);
        if (wd_cnt >= WD_W'(TIMEOUT - 1)) err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_src_arbiter.sv
// Bench for hs_src_arbiter: a small synchronizer model drives hs_sidle,
// directed scenarios push expected {id, payload} words to exp_q, and a
// monitor pops and compares on every hs_sready pulse.
module tb_hs_src_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 26;
  localparam int IDW  = 2;
  localparam int OW   = IDW + DW;
  localparam int GAP  = 6;
`ifdef HS_ARB_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                hs_sready;
  logic [OW-1:0]       hs_din;
  logic                hs_sidle;
  logic                busy;
  logic                err;
  logic [1:0]          dbg_state;

  logic                sidle_force0;
  int                  gap_cnt = 0;

  logic [OW-1:0]       exp_q[$];
  int                  n_checks = 0;
  int                  n_errors = 0;
  logic                prev_sready = 1'b0;

  hs_src_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .TIMEOUT (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hs_sready (hs_sready),
    .hs_din    (hs_din),
    .hs_sidle  (hs_sidle),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronizer model: busy for GAP cycles after seeing sready, sidle low
  // combinationally while sready is high.
  always @(posedge clk) begin
    if (hs_sready)      gap_cnt <= GAP;
    else if (gap_cnt > 0) gap_cnt <= gap_cnt - 1;
  end
  assign hs_sidle = !sidle_force0 && !hs_sready && (gap_cnt == 0);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pay(input int i, input int s);
    return DW'(i * 26'h0100000 + s * 26'h0000111 + 26'h00005A5);
  endfunction

  function automatic logic [OW-1:0] word(input int i, input logic [DW-1:0] p);
    logic [IDW-1:0] id;
    id = IDW'(i);
    return {id, p};
  endfunction

  // Scoreboard monitor: every sready pulse must match the head of exp_q.
  always @(negedge clk) begin
    logic [OW-1:0]   e;
    logic [NREQ-1:0] oh;
    if (rst_n && hs_sready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", hs_din, 0);
      end else begin
        e  = exp_q.pop_front();
        oh = NREQ'(1) << e[OW-1 -: IDW];
        check("hs_din", hs_din, e);
        check("req_ready", req_ready, oh);
        check("busy_in_issue", busy, 1);
        check("sready_1cyc", prev_sready, 0);
      end
    end
    prev_sready <= hs_sready;
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(dbg_state == 2'd0 && hs_sidle) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_idle_timeout"}, 0, 1);
  endtask

  task automatic wait_pulse(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hs_sready && n < 200);
    if (!hs_sready) check({tag, "_pulse_timeout"}, 0, 1);
  endtask

  initial begin
    int seq[NREQ];
    int order[5];
    int grants;
    int cyc;

    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    sidle_force0 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sready", hs_sready, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_din", hs_din, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // All four valid continuously: rotation 0,1,2,3,0, data advances on accept.
    @(negedge clk);
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) begin
      seq[i] = 0;
      req_data[i*DW +: DW] = pay(i, 0);
    end
    for (int k = 0; k < 5; k++) exp_q.push_back(word(order[k], pay(order[k], (k == 4) ? 1 : 0)));
    req_valid = 4'hF;
    grants = 0;
    cyc = 0;
    while (grants < 5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (hs_sready) begin
        grants++;
        for (int i = 0; i < NREQ; i++) begin
          if (req_ready[i]) begin
            seq[i]++;
            req_data[i*DW +: DW] = pay(i, seq[i]);
          end
        end
        if (grants == 5) req_valid = '0;
      end
    end
    check("rot_grants", grants, 5);
    wait_idle("rot");
    check("rot_q_empty", exp_q.size(), 0);

    // Requester 1 alone.
    @(negedge clk);
    req_data[1*DW +: DW] = 26'h0ABCDEF;
    exp_q.push_back({2'd1, 26'h0ABCDEF});
    req_valid = 4'b0010;
    @(negedge clk);
    check("r1_sready", hs_sready, 1);
    check("r1_state_issue", dbg_state, 1);
    req_valid = '0;
    @(negedge clk);
    check("r1_state_wait", dbg_state, 2);
    check("r1_busy_wait", busy, 1);
    check("r1_sready_low", hs_sready, 0);
    wait_idle("r1");

    // hs_sidle held low in IDLE: nothing issued until it is released.
    @(negedge clk);
    sidle_force0 = 1'b1;
    req_data[3*DW +: DW] = pay(3, 7);
    exp_q.push_back(word(3, pay(3, 7)));
    req_valid = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("hold_sready", hs_sready, 0);
      check("hold_busy", busy, 0);
    end
    sidle_force0 = 1'b0;
    @(negedge clk);
    check("hold_release_sready", hs_sready, 1);
    check("hold_release_ready", req_ready, 4'b1000);
    req_valid = '0;
    wait_idle("hold");

    // Reset while in WAIT after a grant to 2.
    @(negedge clk);
    req_data[2*DW +: DW] = pay(2, 9);
    exp_q.push_back(word(2, pay(2, 9)));
    req_valid = 4'b0100;
    wait_pulse("rw");
    req_valid = '0;
    @(negedge clk);
    check("rw_state_wait", dbg_state, 2);
    rst_n = 1'b0;
    #1;
    check("rw_sready", hs_sready, 0);
    check("rw_req_ready", req_ready, 0);
    check("rw_din", hs_din, 0);
    check("rw_busy", busy, 0);
    check("rw_err", err, 0);
    check("rw_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle("rw");
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = pay(i, 3);
    exp_q.push_back(word(0, pay(0, 3)));
    req_valid = 4'hF;
    wait_pulse("rw_next");
    check("rw_next_ready", req_ready, 4'b0001);
    req_valid = '0;
    wait_idle("rw_next");

    // hs_sidle stuck low after issue: watchdog (when built) flags after 10 WAIT cycles.
    @(negedge clk);
    req_data[1*DW +: DW] = pay(1, 5);
    exp_q.push_back(word(1, pay(1, 5)));
    req_valid = 4'b0010;
    wait_pulse("to");
    req_valid = '0;
    sidle_force0 = 1'b1;
    repeat (10) @(negedge clk);
    check("to_before_limit", err, 0);
    @(negedge clk);
    check("to_at_limit", err, TO_EN);
    check("to_state_wait", dbg_state, 2);
    repeat (20) @(negedge clk);
    check("to_sticky", err, TO_EN);
    check("to_still_wait", dbg_state, 2);
    check("to_no_sready", hs_sready, 0);
    sidle_force0 = 1'b0;
    wait_idle("to");
    check("to_after_idle", err, TO_EN);
    check("to_q_empty", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("to_rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
